// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift/subtract on operand magnitudes, one quotient
// bit per clock, then a single sign-fixup cycle. Start/ready handshake as the Booth multiplier.
module booth_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StDivide, StFix, StDone} state_e;

  state_e           state_q;
  // Partial remainder never reaches dmag, so its extra sign bit lives only in the trial.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dmag_q;
  logic [CntW-1:0]  count_q;
  logic             sign_n_q;
  logic             sign_d_q;
  logic             ovf_pend_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             ready_q;
  logic             busy_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             min_neg_n;
  logic             last_step;

  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dmag_q};
    rem_step  = shifted[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
    n_mag     = N[WIDTH-1] ? (~N + WIDTH'(1)) : N;
    d_mag     = D[WIDTH-1] ? (~D + WIDTH'(1)) : D;
    q_fix     = (sign_n_q ^ sign_d_q) ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix     = sign_n_q ? (~rem_q + WIDTH'(1)) : rem_q;
    min_neg_n = (N == {1'b1, {(WIDTH-1){1'b0}}});
    last_step = (count_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      dmag_q     <= '0;
      count_q    <= '0;
      sign_n_q   <= 1'b0;
      sign_d_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sign_n_q   <= N[WIDTH-1];
            sign_d_q   <= D[WIDTH-1];
            dmag_q     <= d_mag;
            quo_q      <= n_mag;
            rem_q      <= '0;
            count_q    <= '0;
            ovf_pend_q <= min_neg_n && (D == '1);
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            if (D == '0) begin
              q_q     <= '1;
              r_q     <= N;
              dbz_q   <= 1'b1;
              ready_q <= 1'b1;
              state_q <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StDivide;
            end
          end
        end
        StDivide: begin
          rem_q   <= rem_step;
          quo_q   <= quo_step;
          count_q <= count_q + 1'b1;
          if (last_step) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // -2^(W-1) / -1 cannot be represented: the quotient wraps to itself.
          if (ovf_pend_q) begin
            q_q <= {1'b1, {(WIDTH-1){1'b0}}};
            r_q <= '0;
          end else begin
            q_q <= q_fix;
            r_q <= r_fix;
          end
          ovf_q   <= ovf_pend_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider (WIDTH=4): fixed vectors, hand-written control sequences and random
// operands checked against an integer-arithmetic reference.
module tb_booth_divider;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] N = '0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         ready;
  logic         busy;
  logic         div_by_zero;
  logic         overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .N           (N),
    .D           (D),
    .Q           (Q),
    .R           (R),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: truncating integer division, remainder sign follows the dividend.
  task automatic ref_div(input logic [W-1:0] n, input logic [W-1:0] d, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic dbz, output logic ovf);
    int ni;
    int di;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (di == 0) begin
      q = '1;
      r = n;
      dbz = 1'b1;
      ovf = 1'b0;
    end else begin
      q = W'(ni / di);
      r = W'(ni % di);
      dbz = 1'b0;
      ovf = (ni == -(1 << (W - 1))) && (di == -1);
    end
  endtask

  // Called #1 after a rising edge; returns the edge count until ready (20 = timed out).
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, output int lat,
                        output logic bseen);
    N = n;
    D = d;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    bseen = busy;
    while (!ready && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      bseen |= busy;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                              input int lat, input logic bseen);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    logic         eovf;
    ref_div(n, d, eq, er, edbz, eovf);
    check({name, ".lat"}, lat, (d == '0) ? 1 : W + 2);
    check({name, ".Q"}, Q, eq);
    check({name, ".R"}, R, er);
    check({name, ".dbz"}, div_by_zero, edbz);
    check({name, ".ovf"}, overflow, eovf);
    check({name, ".busy_seen"}, bseen, (d != '0));
    check({name, ".busy_end"}, busy, 1'b0);
  endtask

  vec_t         vecs[$];
  int           lat;
  logic         bseen;
  logic [W-1:0] rn;
  logic [W-1:0] rd;

  initial begin
    vecs.push_back('{4'd7, 4'd2, 4'h3, 4'h1, 1'b0, 1'b0, 6});
    vecs.push_back('{4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 6});  // -7 / 2
    vecs.push_back('{4'd7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 6});  // 7 / -2
    vecs.push_back('{4'h9, 4'hE, 4'h3, 4'hF, 1'b0, 1'b0, 6});  // -7 / -2
    vecs.push_back('{4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0, 6});  // -8 / 3
    vecs.push_back('{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 6});  // -8 / -1
    vecs.push_back('{4'h8, 4'd1, 4'h8, 4'h0, 1'b0, 1'b0, 6});  // -8 / 1
    vecs.push_back('{4'd5, 4'd0, 4'hF, 4'h5, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd0, 4'd5, 4'h0, 4'h0, 1'b0, 1'b0, 6});
    vecs.push_back('{4'd7, 4'd7, 4'h1, 4'h0, 1'b0, 1'b0, 6});
    vecs.push_back('{4'hF, 4'd7, 4'h0, 4'hF, 1'b0, 1'b0, 6});  // -1 / 7

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst.Q", Q, 0);
    check("rst.R", R, 0);
    check("rst.ready", ready, 0);
    check("rst.busy", busy, 0);
    check("rst.dbz", div_by_zero, 0);
    check("rst.ovf", overflow, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Edge-by-edge handshake for 7/2.
    N = 4'd7;
    D = 4'd2;
    start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #1;
      start = 1'b0;
      check($sformatf("seq72.busy@%0d", e), busy, (e <= 5));
      check($sformatf("seq72.ready@%0d", e), ready, (e == 6));
      if (e < 6) check($sformatf("seq72.Qhold@%0d", e), Q, 0);
    end
    check("seq72.Q", Q, 4'h3);
    check("seq72.R", R, 4'h1);

    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, lat, bseen);
      check($sformatf("vec%0d.lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d.Q", i), Q, vecs[i].q);
      check($sformatf("vec%0d.R", i), R, vecs[i].r);
      check($sformatf("vec%0d.dbz", i), div_by_zero, vecs[i].dbz);
      check($sformatf("vec%0d.ovf", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d.busy_seen", i), bseen, (vecs[i].d != '0));
    end

    // start and operand changes while busy must be ignored.
    N = 4'd6;
    D = 4'd3;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    N = 4'd1;
    D = 4'd1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    N = 4'd7;
    D = 4'd5;
    lat = 3;
    while (!ready && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ign.lat", lat, 6);
    check("ign.Q", Q, 4'h2);
    check("ign.R", R, 4'h0);

    // Reset mid-division.
    N = 4'd7;
    D = 4'd2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mrst.Q", Q, 0);
    check("mrst.R", R, 0);
    check("mrst.ready", ready, 0);
    check("mrst.busy", busy, 0);
    check("mrst.dbz", div_by_zero, 0);
    check("mrst.ovf", overflow, 0);
    repeat (3) @(posedge clock);
    #1;
    check("mrst.idle_ready", ready, 0);
    check("mrst.idle_busy", busy, 0);
    run_op(4'd4, 4'd2, lat, bseen);
    check_result("mrst.after", 4'd4, 4'd2, lat, bseen);

    // start held high: back-to-back operations, ready high for one cycle each.
    N = 4'd7;
    D = 4'd2;
    start = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clock); #1;
      check($sformatf("b2b.ready@%0d", e), ready, (e % 6 == 0));
    end
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("b2b.Q", Q, 4'h3);

    for (int i = 0; i < 200; i++) begin
      rn = W'($urandom);
      rd = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      run_op(rn, rd, lat, bseen);
      check_result($sformatf("rnd%0d(%0h/%0h)", i, rn, rd), rn, rd, lat, bseen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
